pd_pluse_seq: RTL and testbench

CPMG pulse-sequence controller directly upstream of `pd_pluse_timer`. It drives the timer's `pluse_start`/`stateover` enables and consumes its 16-bit `count` to time each phase: 90° pulse, first gap, then N × (180° pulse, echo window). It produces the RF gate, RF phase select, acquisition window and echo index for the transmitter and ADC stages, all on the `dds` clock.

---
 rtl/pd_pluse_pkg.sv | 19 +
 rtl/pd_pluse_dur_mux.sv | 31 +++
 rtl/pd_pluse_seq.sv | 97 +++++++++
 tb/tb_pd_pluse_seq.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pd_pluse_pkg.sv
// Shared types and helpers for the CPMG pulse-sequence controller.
package pd_pluse_pkg;
  localparam int CNT_W_DEF  = 16;
  localparam int ECHO_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P90  = 3'd1,
    ST_GAP1 = 3'd2,
    ST_P180 = 3'd3,
    ST_ECHO = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // A programmed duration of 0 still occupies one cycle.
  function automatic logic [31:0] eff_dur(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction
endpackage

// File: rtl/pd_pluse_dur_mux.sv
// Picks the shadow duration for the current phase and flags its last cycle.
module pd_pluse_dur_mux
  import pd_pluse_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic [2:0]       state,
  input  logic [CNT_W-1:0] w90,
  input  logic [CNT_W-1:0] tau1,
  input  logic [CNT_W-1:0] w180,
  input  logic [CNT_W-1:0] tau2,
  input  logic [CNT_W-1:0] count,
  output logic             phase_end
);
  logic [CNT_W-1:0] sel;
  logic [31:0]      last;

  always_comb begin
    sel = '0;
    case (state_t'(state))
      ST_P90:  sel = w90;
      ST_GAP1: sel = tau1;
      ST_P180: sel = w180;
      ST_ECHO: sel = tau2;
      default: sel = '0;
    endcase
    last = eff_dur(32'(sel)) - 32'd1;
    // An overshooting count also ends the phase so a misbehaving timer cannot hang us.
    phase_end = (32'(count) >= last);
  end
endmodule

// File: rtl/pd_pluse_seq.sv
// CPMG sequencer: 90, gap, then N x (180, echo window), timed by pd_pluse_timer.
module pd_pluse_seq
  import pd_pluse_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ECHO_W = ECHO_W_DEF
) (
  input  logic              dds,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  w90,
  input  logic [CNT_W-1:0]  tau1,
  input  logic [CNT_W-1:0]  w180,
  input  logic [CNT_W-1:0]  tau2,
  input  logic [ECHO_W-1:0] echo_num,
  input  logic [CNT_W-1:0]  count,
  output logic              pluse_start,
  output logic              stateover,
  output logic              rf_gate,
  output logic              rf_phase,
  output logic              acq_win,
  output logic [ECHO_W-1:0] echo_idx,
  output logic              busy,
  output logic              done
);
  state_t            state, nxt;
  logic [CNT_W-1:0]  sh_w90, sh_tau1, sh_w180, sh_tau2;
  logic [ECHO_W-1:0] sh_echo;
  logic              phase_end, more, nxt_busy;

  pd_pluse_dur_mux #(.CNT_W(CNT_W)) u_dur (
    .state     (state),
    .w90       (sh_w90),
    .tau1      (sh_tau1),
    .w180      (sh_w180),
    .tau2      (sh_tau2),
    .count     (count),
    .phase_end (phase_end)
  );

  assign more = ({1'b0, echo_idx} + (ECHO_W+1)'(1)) < {1'b0, sh_echo};

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (start) nxt = ST_P90;
      ST_P90:  if (stop) nxt = ST_DONE; else if (phase_end) nxt = ST_GAP1;
      ST_GAP1: if (stop) nxt = ST_DONE;
               else if (phase_end) nxt = (sh_echo != '0) ? ST_P180 : ST_DONE;
      ST_P180: if (stop) nxt = ST_DONE; else if (phase_end) nxt = ST_ECHO;
      ST_ECHO: if (stop) nxt = ST_DONE;
               else if (phase_end) nxt = more ? ST_P180 : ST_DONE;
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  assign nxt_busy = (nxt == ST_P90) || (nxt == ST_GAP1) ||
                    (nxt == ST_P180) || (nxt == ST_ECHO);

  always_ff @(posedge dds or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pluse_start <= 1'b0;
      echo_idx    <= '0;
      sh_w90      <= '0;
      sh_tau1     <= '0;
      sh_w180     <= '0;
      sh_tau2     <= '0;
      sh_echo     <= '0;
    end else begin
      state       <= nxt;
      pluse_start <= nxt_busy;
      if (state == ST_IDLE && start) begin
        sh_w90  <= w90;
        sh_tau1 <= tau1;
        sh_w180 <= w180;
        sh_tau2 <= tau2;
        sh_echo <= echo_num;
      end
      // Index survives into DONE so downstream can see the last echo served.
      if (nxt == ST_P90 || state == ST_DONE)
        echo_idx <= '0;
      else if (state == ST_ECHO && nxt == ST_P180)
        echo_idx <= echo_idx + ECHO_W'(1);
    end
  end

  assign busy      = (state == ST_P90) || (state == ST_GAP1) ||
                     (state == ST_P180) || (state == ST_ECHO);
  assign stateover = busy & ~phase_end;
  assign rf_gate   = (state == ST_P90) || (state == ST_P180);
  assign rf_phase  = (state == ST_P180);
  assign acq_win   = (state == ST_ECHO);
  assign done      = (state == ST_DONE);
endmodule

// File: tb/tb_pd_pluse_seq.sv
// Directed bench for pd_pluse_seq with a behavioural timer closing the loop.
module tb_pd_pluse_seq;
  localparam int CW = 16;
  localparam int EW = 16;

  logic          dds = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [CW-1:0] w90 = '0, tau1 = '0, w180 = '0, tau2 = '0, count;
  logic [EW-1:0] echo_num = '0, echo_idx;
  logic          pluse_start, stateover, rf_gate, rf_phase, acq_win, busy, done;

  typedef struct packed {
    logic          busy, ps, gate, phase, acq, done;
    logic [EW-1:0] idx;
    logic [CW-1:0] cnt;
  } obs_t;

  obs_t obs;
  obs_t q[$];
  int   n_vec = 0, n_bad = 0;

  pd_pluse_seq #(.CNT_W(CW), .ECHO_W(EW)) dut (
    .dds(dds), .rst(rst), .start(start), .stop(stop),
    .w90(w90), .tau1(tau1), .w180(w180), .tau2(tau2), .echo_num(echo_num),
    .count(count), .pluse_start(pluse_start), .stateover(stateover),
    .rf_gate(rf_gate), .rf_phase(rf_phase), .acq_win(acq_win),
    .echo_idx(echo_idx), .busy(busy), .done(done)
  );

  always #5 dds = ~dds;

  // Stand-in for pd_pluse_timer: counts while held, clears when released.
  always_ff @(posedge dds or posedge rst)
    if (rst) count <= '0;
    else     count <= stateover ? count + CW'(1) : '0;

  assign obs = {busy, pluse_start, rf_gate, rf_phase, acq_win, done, echo_idx, count};

  function automatic obs_t mk(logic b, logic g, logic ph, logic a, logic d, int idx, int cnt);
    return {b, b, g, ph, a, d, EW'(idx), CW'(cnt)};
  endfunction

  function automatic int e(int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic push_phase(logic g, logic ph, logic a, int len, int idx);
    for (int c = 0; c < len; c++) q.push_back(mk(1'b1, g, ph, a, 1'b0, idx, c));
  endtask

  task automatic push_seq(int a90, int t1, int a180, int t2, int n);
    push_phase(1'b1, 1'b0, 1'b0, e(a90), 0);
    push_phase(1'b0, 1'b0, 1'b0, e(t1), 0);
    for (int k = 0; k < n; k++) begin
      push_phase(1'b1, 1'b1, 1'b0, e(a180), k);
      push_phase(1'b0, 1'b0, 1'b1, e(t2), k);
    end
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (n == 0) ? 0 : n - 1, 0));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0));
  endtask

  task automatic check(string tag);
    obs_t x;
    x = q.pop_front();
    n_vec++;
    assert (obs === x) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, x);
    end
  endtask

  task automatic load(int a90, int t1, int a180, int t2, int n);
    w90 = CW'(a90); tau1 = CW'(t1); w180 = CW'(a180); tau2 = CW'(t2);
    echo_num = EW'(n); start = 1'b1;
  endtask

  // One check per cycle until the scoreboard drains; optional stop/disturb hooks.
  task automatic run(string tag, int stop_at, int mod_at);
    int i;
    i = 0;
    while (q.size() > 0) begin
      @(negedge dds);
      check(tag);
      start = 1'b0;
      stop  = (i == stop_at);
      if (i == mod_at) begin
        start = 1'b1;
        w180  = CW'(1);
      end
      i++;
    end
  endtask

  initial begin
    repeat (3) @(negedge dds);
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0));
    check("reset");
    rst = 1'b0;

    load(4, 10, 8, 20, 2);
    push_seq(4, 10, 8, 20, 2);
    run("cpmg2", -1, -1);

    load(3, 5, 0, 0, 0);
    stop = 1'b1;
    push_seq(3, 5, 0, 0, 0);
    run("no_echo", -1, -1);

    load(0, 0, 0, 0, 1);
    push_seq(0, 0, 0, 0, 1);
    run("all_zero", -1, -1);

    load(2, 3, 4, 10, 3);
    push_phase(1'b1, 1'b0, 1'b0, 2, 0);
    push_phase(1'b0, 1'b0, 1'b0, 3, 0);
    push_phase(1'b1, 1'b1, 1'b0, 4, 0);
    push_phase(1'b0, 1'b0, 1'b1, 5, 0);
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 5));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0));
    run("stop_echo", 13, -1);

    load(3, 4, 5, 6, 2);
    push_seq(3, 4, 5, 6, 2);
    run("latched", -1, 8);

    load(2, 2, 3, 3, 2);
    push_phase(1'b1, 1'b0, 1'b0, 2, 0);
    push_phase(1'b0, 1'b0, 1'b0, 2, 0);
    push_phase(1'b1, 1'b1, 1'b0, 2, 0);
    run("pre_rst", -1, -1);
    #2 rst = 1'b1;
    #1;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0));
    check("rst_async");
    for (int k = 0; k < 3; k++) begin
      @(negedge dds);
      q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0));
      check("rst_hold");
    end
    rst = 1'b0;
    @(negedge dds);
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0));
    check("rst_release");

    load(4, 10, 8, 20, 2);
    push_seq(4, 10, 8, 20, 2);
    run("post_rst", -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
